// File: rtl/instruction_fetch.sv
// Instruction fetch stage: walks a 16-entry instruction memory and hands words to
// decode over a valid/ready handshake, honouring jumps, redirects, stalls and halt.
module instruction_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt,
   output logic [3:0]  imem_addr,
   input  logic [15:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [3:0]  redirect_addr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_instr,
   output logic [3:0]  out_pc,
   output logic        running,
   output logic [7:0]  instr_count
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [3:0] JUMP_OPCODE = 4'b1011;

   state_t     state, next_state;
   logic [3:0] pc;
   logic [3:0] next_pc;
   logic       fetch;

   assign imem_addr = pc;
   assign running   = (state == RUN);

   // A new word may enter the output slot only when it is empty or being drained.
   assign fetch   = (state == RUN) && !redirect_valid && (!out_valid || out_ready);
   assign next_pc = (imem_instr[15:12] == JUMP_OPCODE) ? imem_instr[3:0] : pc + 4'd1;

   // NOTE: next_state gets its default first so no path through the block can infer a latch.
   always_comb begin
      next_state = state;
      if (!redirect_valid) begin
         case (state)
            IDLE:    if (start && !halt) next_state = RUN;
            RUN:     if (halt)           next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= 4'd0;
         out_valid   <= 1'b0;
         out_instr   <= 16'h0000;
         out_pc      <= 4'd0;
         instr_count <= 8'd0;
      end else begin
         state <= next_state;

         if (out_valid && out_ready && (instr_count != 8'hFF))
            instr_count <= instr_count + 8'd1;

         if (redirect_valid) begin
            pc        <= redirect_addr;
            out_valid <= 1'b0;
         end else if (fetch) begin
            out_instr <= imem_instr;
            out_pc    <= pc;
            out_valid <= 1'b1;
            pc        <= next_pc;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
